// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg: FSM encodings, burst and size constants shared by the bridge.
package sram_axi_bridge_pkg;
    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction
endpackage

// File: rtl/axi_wr_ctrl.sv
// axi_wr_ctrl: single-outstanding AXI write channel (AW + W issue, B wait) for the bridge.
module axi_wr_ctrl
    import sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [3:0]        strb,
    input  logic [31:0]       data,
    output logic              idle,
    output logic              done,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);
    w_state_t state, state_nxt;
    logic aw_left, w_left;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= W_IDLE;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else begin
            state   <= state_nxt;
            awvalid <= start | (awvalid & ~awready);
            wvalid  <= start | (wvalid & ~wready);
        end
    end
    always_ff @(posedge clk) begin
        if (start) begin
            awaddr <= addr;
            awsize <= axi_size(size);
            wdata  <= data;
            wstrb  <= strb;
        end
    end
    // AW and W may complete in either order; leave W_ADDR once neither is still pending
    always_comb begin
        aw_left   = awvalid & ~awready;
        w_left    = wvalid & ~wready;
        state_nxt = (state == W_IDLE && start) ? W_ADDR :
                    (state == W_ADDR && !aw_left && !w_left) ? W_RESP :
                    (state == W_RESP && bvalid) ? W_IDLE : state;
        idle      = state == W_IDLE;
        bready    = state == W_RESP;
        done      = bvalid & bready;
    end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: SRAM-like inst/data ports to a single-beat AXI master.
// Define BRIDGE_RAW_CHECK_EN to hold inst reads that hit the word of an in-flight store.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [1:0]        inst_size,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);
    ar_state_t ar_state, ar_nxt;
    logic inst_pend, data_rd_pend, rready_q;
    logic wr_idle, wr_done, r_inst_ok, r_data_ok;
    logic data_free, data_rd_go, data_wr_go, inst_go, raw_hold;

`ifdef BRIDGE_RAW_CHECK_EN
    assign raw_hold = !wr_idle && inst_addr[ADDR_W-1:2] == awaddr[ADDR_W-1:2];
`else
    assign raw_hold = 1'b0;
`endif

    // data read beats a simultaneous inst read for the single AR slot
    always_comb begin
        data_free    = !reset && !data_rd_pend && wr_idle;
        data_rd_go   = data_req && !data_wr && data_free && ar_state == AR_IDLE;
        data_wr_go   = data_req && data_wr && data_free;
        inst_go      = inst_req && !reset && !inst_pend && ar_state == AR_IDLE && !data_rd_go && !raw_hold;
        ar_nxt       = (ar_state == AR_IDLE && (inst_go || data_rd_go)) ? AR_BUSY :
                       (ar_state == AR_BUSY && arready) ? AR_IDLE : ar_state;
        inst_addr_ok = inst_go;
        data_addr_ok = data_rd_go || data_wr_go;
        r_inst_ok    = rvalid && rready && rid == INST_ID;
        r_data_ok    = rvalid && rready && rid == DATA_ID;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state     <= AR_IDLE;
            inst_pend    <= 1'b0;
            data_rd_pend <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            ar_state     <= ar_nxt;
            inst_pend    <= inst_go | (inst_pend & ~r_inst_ok);
            data_rd_pend <= data_rd_go | (data_rd_pend & ~r_data_ok);
            rready_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (inst_go || data_rd_go) begin
            arid   <= data_rd_go ? DATA_ID : INST_ID;
            araddr <= data_rd_go ? data_addr : inst_addr;
            arsize <= axi_size(data_rd_go ? data_size : inst_size);
        end
    end

    assign arvalid      = ar_state == AR_BUSY;
    assign arlen        = 4'd0;
    assign arburst      = BURST_INCR;
    assign rready       = rready_q;
    assign inst_data_ok = r_inst_ok;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;
    assign data_data_ok = r_data_ok || wr_done;
    assign awid         = DATA_ID;
    assign wid          = DATA_ID;
    assign awlen        = 4'd0;
    assign awburst      = BURST_INCR;
    assign wlast        = 1'b1;

    axi_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr (
        .clk     (clk),
        .reset   (reset),
        .start   (data_wr_go),
        .addr    (data_addr),
        .size    (data_size),
        .strb    (data_wstrb),
        .data    (data_wdata),
        .idle    (wr_idle),
        .done    (wr_done),
        .awaddr  (awaddr),
        .awsize  (awsize),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bvalid  (bvalid),
        .bready  (bready)
    );
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: random CPU traffic and AXI slave with a queue scoreboard for sram_axi_bridge.
module tb_sram_axi_bridge;
    localparam logic [3:0] IID = 4'd0;
    localparam logic [3:0] DID = 4'd1;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [1:0] inst_size;
    logic data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0] data_size;
    logic [3:0] data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0] arid, arlen, rid, awid, awlen, wid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst;
    logic arvalid, arready, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    sram_axi_bridge #(.ADDR_W(32), .INST_ID(IID), .DATA_ID(DID)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [2:0] size;} ar_t;
    typedef struct packed {logic wr; logic [31:0] val;} dexp_t;

    ar_t ar_q[$], r_q[$], ae;
    dexp_t data_q[$], de;
    logic [31:0] inst_q[$];
    logic [34:0] aw_q[$];
    logic [35:0] w_q[$];
    int errs = 0, checks = 0;
    int aw_n, w_n, b_pend, n_inst_ok, n_rd_ok, n_wr_ok;
    logic i_busy, d_busy, ar_busy, w_busy, i_taken, d_taken, ar_wait, ei, ed, raw;
    logic [31:0] w_addr, ar_paddr;

    // slave memory contents are a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) * 32'h9E3779B1) ^ 32'h0280_0C0C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errs++;
        $display("FAIL %s: event with no expected entry", name);
    endtask

    task automatic clear_model();
        ar_q.delete(); r_q.delete(); data_q.delete(); inst_q.delete(); aw_q.delete(); w_q.delete();
        aw_n = 0; w_n = 0; b_pend = 0;
        i_busy = 0; d_busy = 0; ar_busy = 0; w_busy = 0; i_taken = 0; d_taken = 0; ar_wait = 0;
        w_addr = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ar_wait) chk("ar_stable", {arvalid, araddr}, {1'b1, ar_paddr});
            ed = data_req && !d_busy && (data_wr || !ar_busy);
            raw = 1'b0;
`ifdef BRIDGE_RAW_CHECK_EN
            raw = w_busy && inst_addr[31:2] == w_addr[31:2];
`endif
            ei = inst_req && !i_busy && !ar_busy && !(ed && !data_wr) && !raw;
            chk("inst_addr_ok", inst_addr_ok, ei);
            chk("data_addr_ok", data_addr_ok, ed);
            if (inst_req && inst_addr_ok) begin
                ar_q.push_back('{IID, inst_addr, {1'b0, inst_size}});
                inst_q.push_back(mem_word(inst_addr));
                i_busy = 1; ar_busy = 1; i_taken = 1;
            end
            if (data_req && data_addr_ok) begin
                d_busy = 1; d_taken = 1;
                if (data_wr) begin
                    aw_q.push_back({1'b0, data_size, data_addr});
                    w_q.push_back({data_wstrb, data_wdata});
                    data_q.push_back('{1'b1, 32'd0});
                    w_busy = 1; w_addr = data_addr;
                end else begin
                    ar_q.push_back('{DID, data_addr, {1'b0, data_size}});
                    data_q.push_back('{1'b0, mem_word(data_addr)});
                    ar_busy = 1;
                end
            end
            if (arvalid && arready) begin
                if (ar_q.size() == 0) bad("ar_handshake");
                else begin
                    ae = ar_q.pop_front();
                    chk("arid", arid, ae.id);
                    chk("araddr", araddr, ae.addr);
                    chk("arsize", arsize, ae.size);
                    chk("arlen_arburst", {arlen, arburst}, {4'd0, 2'b01});
                end
                r_q.push_back('{arid, araddr, arsize});
                ar_busy = 0;
            end
            if (awvalid && awready) begin
                if (aw_q.size() == 0) bad("aw_handshake");
                else chk("aw_size_addr", {awsize, awaddr}, aw_q.pop_front());
                chk("awid_wid_len", {awid, wid, awlen, awburst}, {DID, DID, 4'd0, 2'b01});
                aw_n++;
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) bad("w_handshake");
                else chk("w_strb_data", {wstrb, wdata}, w_q.pop_front());
                chk("wlast", wlast, 1'b1);
                w_n++;
            end
            if (aw_n > 0 && w_n > 0) begin aw_n--; w_n--; b_pend++; end
            if (rvalid && rready && r_q.size() > 0) void'(r_q.pop_front());
            if (bvalid && bready) b_pend--;
            if (inst_data_ok) begin
                if (inst_q.size() == 0) bad("inst_data_ok");
                else chk("inst_rdata", inst_rdata, inst_q.pop_front());
                i_busy = 0; n_inst_ok++;
            end
            if (data_data_ok) begin
                if (data_q.size() == 0) bad("data_data_ok");
                else begin
                    de = data_q.pop_front();
                    if (de.wr) begin
                        chk("store_ok_on_b", {bvalid, bready}, 2'b11);
                        w_busy = 0; n_wr_ok++;
                    end else begin
                        chk("data_rdata", data_rdata, de.val);
                        n_rd_ok++;
                    end
                end
                d_busy = 0;
            end
            ar_wait = arvalid && !arready;
            ar_paddr = araddr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        end else begin
            arready = $urandom_range(0, 2) != 0;
            awready = $urandom_range(0, 2) != 0;
            wready  = $urandom_range(0, 2) != 0;
            rvalid  = r_q.size() > 0 && $urandom_range(0, 1) == 1;
            if (rvalid) begin rid = r_q[0].id; rdata = mem_word(r_q[0].addr); end
            bvalid  = b_pend > 0 && (bvalid || $urandom_range(0, 1) == 1);
        end
    end

    task automatic new_inst();
        inst_req  = $urandom_range(0, 2) == 0;
        inst_addr = ($urandom_range(0, 1) == 1 ? 32'h1C00_0000 : 32'h100) + 4 * $urandom_range(0, 7);
        inst_size = 2'($urandom_range(0, 2));
    endtask

    task automatic new_data();
        data_req   = $urandom_range(0, 2) == 0;
        data_wr    = $urandom_range(0, 1) == 1;
        data_addr  = 32'h100 + 4 * $urandom_range(0, 7);
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom_range(0, 15));
        data_wdata = $urandom;
    endtask

    initial begin
        inst_req = 0; inst_addr = 0; inst_size = 0;
        data_req = 0; data_wr = 0; data_addr = 0; data_size = 0; data_wstrb = 0; data_wdata = 0;
        rid = 0; rdata = 0;
        n_inst_ok = 0; n_rd_ok = 0; n_wr_ok = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {arvalid, awvalid, wvalid, bready, rready, inst_data_ok, data_data_ok},  7'd0);
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #2 chk("rready_after_reset", rready, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (c == 2000) begin
                #1 reset = 1; inst_req = 0; data_req = 0;
                clear_model();
                @(posedge clk); #2;
                chk("mid_reset_outputs", {arvalid, awvalid, wvalid, bready, rready, inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 9'd0);
                @(posedge clk); #1 reset = 0;
                @(posedge clk); #2 chk("rready_after_mid_reset", rready, 1'b1);
            end else begin
                if (!inst_req || i_taken) begin i_taken = 0; new_inst(); end
                if (!data_req || d_taken) begin d_taken = 0; new_data(); end
            end
        end
        @(posedge clk); #1 inst_req = 0; data_req = 0;
        for (int t = 0; t < 300 && (inst_q.size() + data_q.size() + ar_q.size() + aw_q.size() + w_q.size() > 0); t++)
            @(posedge clk);
        chk("drain_outstanding", inst_q.size() + data_q.size() + ar_q.size() + aw_q.size() + w_q.size(), 0);
        chk("inst_reads_completed", n_inst_ok > 50, 1'b1);
        chk("data_reads_completed", n_rd_ok > 20, 1'b1);
        chk("stores_completed", n_wr_ok > 20, 1'b1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter ADDR_W, 32, address width of both CPU ports and AXI.
REQ-002 Parameter INST_ID, 4'd0, ARID/RID tag for instruction fetches.
REQ-003 Parameter DATA_ID, 4'd1, ARID/RID tag for data reads; also the AWID.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 inst_req/inst_addr/inst_size  in  1/ADDR_W/2  fetch request (read only).
REQ-007 inst_addr_ok/inst_data_ok/inst_rdata  out  1/1/32  fetch accept, return, data.
REQ-008 data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata  in  1/1/2/4/ADDR_W/32  load/store request.
REQ-009 data_addr_ok/data_data_ok/data_rdata  out  1/1/32  load/store accept, completion, load data.
REQ-010 arid/araddr/arsize/arvalid  out  4/ADDR_W/3/1; arready in 1.
REQ-011 rid/rdata/rvalid  in  4/32/1; rready out 1.
REQ-012 awid/awaddr/awsize/awvalid  out  4/ADDR_W/3/1; awready in 1.
REQ-013 wdata/wstrb/wvalid  out  32/4/1; wready in 1.
REQ-014 bvalid in 1; bready out 1.
REQ-015 arlen/awlen SHALL be constant 0, arburst/awburst constant INCR, wlast constant 1, wid = awid.

Function
REQ-016 A request is accepted in the cycle where req and addr_ok are both 1; addr_ok SHALL be combinational from req and bridge state.
REQ-017 Each port SHALL have at most one outstanding transaction; addr_ok = 0 while one is pending.
REQ-018 Read FSM: AR_IDLE -> AR_BUSY on accepted read; AR_BUSY -> AR_IDLE on arvalid&arready.
REQ-019 arvalid/arid/araddr/arsize SHALL be registered: asserted the cycle after acceptance and held stable until arready.
REQ-020 Reads are accepted only in AR_IDLE; if inst and data read requests coincide, data wins and inst_addr_ok = 0 that cycle.
REQ-021 rready SHALL be constant 1 after reset; rvalid with rid == INST_ID raises inst_data_ok and rid == DATA_ID raises data_data_ok for that cycle, with rdata passed through combinationally.
REQ-022 Write FSM: W_IDLE -> W_ADDR on accepted write; W_ADDR -> W_RESP once both AW and W handshakes have completed (in either order or the same cycle); W_RESP -> W_IDLE on bvalid.
REQ-023 awvalid and wvalid SHALL assert together the cycle after acceptance and deassert independently on their own handshakes.
REQ-024 bready SHALL be 1 only in W_RESP; data_data_ok pulses for one cycle on bvalid&bready.
REQ-025 data_size maps to arsize/awsize zero-extended to 3 bits; data_wstrb and data_wdata are registered unmodified.
REQ-026 A data write is accepted only in W_IDLE with no data read pending; a data read only in AR_IDLE with no data write pending.

Reset
REQ-027 On reset: all valid outputs, addr_ok, data_ok and bready = 0; rready = 0 during reset and 1 from the first cycle after; FSMs -> *_IDLE; pending flags cleared.
REQ-028 Reset mid-transaction SHALL abandon it without a data_ok; the AXI slave is reset in the same cycle.

Configuration
REQ-029 Macro BRIDGE_RAW_CHECK_EN defined: an inst read whose word address matches a write in W_ADDR/W_RESP SHALL be held (inst_addr_ok = 0) until that write's bvalid.
REQ-030 Macro undefined: no address comparison; inst reads proceed regardless of pending writes.

Structure
REQ-031 The shared header SHALL hold the AR/W FSM state encodings, INCR burst constant and size encodings.
REQ-032 The write channel (REQ-022..024) SHALL be a sub-module named axi_wr_ctrl; read path and arbitration stay in sram_axi_bridge.

Verification
REQ-033 Inst read 0x1C000000, arready after 2 cycles, rvalid rid=0 rdata=0x02800C0C -> one inst_data_ok with inst_rdata=0x02800C0C.
REQ-034 Inst and data read requests in the same cycle -> data_addr_ok=1, inst_addr_ok=0; arid=1 issued first, inst issued after.
REQ-035 Store addr 0x100 wstrb 4'b0011 wdata 0x0000BEEF, awready on cycle 1, wready on cycle 3 -> W_RESP after cycle 3; data_data_ok only on bvalid.
REQ-036 Second data request while a load is pending -> data_addr_ok=0 until the rid=1 return.
REQ-037 Reset asserted in AR_BUSY -> next cycle arvalid=0, no data_ok; first read after reset completes normally.
REQ-038 With BRIDGE_RAW_CHECK_EN, inst read 0x100 during pending store 0x100 -> inst_addr_ok held 0 until bvalid, then 1.
